mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Sequencing controller and arbiter for the CPU's single byte-wide RAM port. It accepts 32-bit-oriented requests from the instruction-fetch stage and the memory stage. It serialises each request into 1, 2 or 4 byte-wide RAM accesses and reassembles little-endian read data. It sits between the pipeline (IF, MEM) and the RAM, and is the only block that drives the RAM address and write strobe.

## Interface
- ADDR_W, 17, RAM byte-address width (matches `RamAddrBus`)
- DATA_W, 32, word width (matches `RegBus`)
- clk  in  1  system clock; everything is sampled on its rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable`).
- if_req_i  in  1  fetch request; word read.
- if_addr_i  in  ADDR_W  fetch byte address.
- if_data_o  out  DATA_W  fetched word.
- if_done_o  out  1  one-cycle completion pulse for fetch.
- mem_req_i  in  1  memory-stage request.
- mem_wr_i  in  1  1 = store, 0 = load.
- mem_width_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- mem_addr_i  in  ADDR_W  load/store byte address.
- mem_wdata_i  in  DATA_W  store data; low bytes are used for narrow widths.
- mem_data_o  out  DATA_W  load data, zero-extended. Sign extension belongs to the MEM stage.
- mem_done_o  out  1  one-cycle completion pulse for load/store.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_data_o  out  8  RAM write byte.
- ram_wr_o  out  1  RAM write enable.
- ram_data_i  in  8  RAM read byte. Valid one cycle after its address is driven.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: sample requests each edge.
  - mem_req_i has priority over if_req_i.
  - Latch base address, byte count n (1/2/4), store data and owner.
  - Clear counter k.
  - Go to READ or WRITE.
- READ:
  - Drive ram_addr_o = base+k.
  - At each edge with k≥1, capture ram_data_i into byte k-1 (bits 8(k-1)+7:8(k-1)).
  - k increments each edge. After byte n-1 is captured, go to DONE.
- WRITE:
  - Drive ram_addr_o = base+k, ram_data_o = byte k of the store data, ram_wr_o = 1.
  - After byte n-1 is written, go to DONE.
- DONE:
  - Pulse the owner's done output; the owner's data output holds the assembled value.
  - Requests are ignored in this state. Next state is IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0x1FFFF+1 wraps to 0x00000.
- Unused upper bytes of a narrow read are zero.
- Data outputs hold their last value until the owner's next completion.
- Requester drops req mid-READ: abort at the next edge to IDLE with no done pulse and data outputs unchanged. This covers IF flush on branch.
- Requester drops req mid-WRITE: the write still completes and done still pulses. Stores are never torn.
- Simultaneous requests in IDLE: mem wins. IF stays pending and is accepted in the IDLE cycle after DONE.
- ram_wr_o is 0 in every state except WRITE.

## Timing
- Acceptance edge is E0.
- Read of n bytes:
  - Addresses are driven in the cycles after E0…E(n-1).
  - The last byte is captured at E(n+1).
  - Done is high in the cycle after E(n+1).
  - Word read: done 5 cycles after acceptance.
- Write of n bytes:
  - Strobes occur in the cycles after E0…E(n-1).
  - Done is high in the cycle after En.
  - Word write: done 4 cycles after acceptance.
- Throughput: one bubble (DONE) plus one IDLE cycle between transactions.
- Requesters hold req and operands stable until done; operands are latched at E0 regardless.
- Reset, asynchronous, effective at any point:
  - State goes to IDLE, k = 0.
  - All outputs are 0: ram_addr_o, ram_data_o, ram_wr_o, if_data_o, mem_data_o, if_done_o, mem_done_o.
  - A store interrupted by reset leaves partially written bytes; this is accepted.

## Structure
- Additions to shared `define.v`:
  - width codes `MemByte`/`MemHalf`/`MemWord`.
  - FSM state encoding `MemCtrlIdle`…`MemCtrlDone`.
  - owner codes `OwnerIf`/`OwnerMem`.
  - reuse of `ByteBus`, `RamAddrBus`, `RegBus`.
- Single module. No sub-module is warranted; the byte assembly is an indexed register write inside mem_ctrl.

## Test plan
- IF word read at 0x00010 with RAM bytes 0x13,0x05,0x00,0x00 → if_data_o=0x00000513, if_done_o high 5 cycles after acceptance; ram_wr_o stays 0.
- MEM store word 0xDEADBEEF at 0x00100 → RAM 0x100..0x103 = EF,BE,AD,DE over 4 consecutive cycles; mem_done_o 4 cycles after acceptance.
- MEM byte load at 0x1FFFF (byte 0x80), then half load at 0x1FFFF → data 0x00000080; the half read addresses 0x1FFFF then 0x00000 (wrap); upper bytes are zero.
- if_req_i and mem_req_i raised in the same cycle → MEM served first; IF accepted in the IDLE cycle after mem_done_o; both results correct.
- IF request dropped after 2 bytes → no if_done_o, if_data_o unchanged. A MEM store with req dropped after byte 1 → all 4 bytes written, mem_done_o pulses.
- rst asserted mid word-write after byte 1 → outputs 0 immediately (asynchronous). After release: IDLE, no done pulse, next request serviced normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM sequencer: width codes, FSM states,
// requester owner codes and the width-to-byte-count helper.
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W = 17;
  localparam int REG_W      = 32;
  localparam int BYTE_W     = 8;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    MEM_CTRL_IDLE  = 2'd0,
    MEM_CTRL_READ  = 2'd1,
    MEM_CTRL_WRITE = 2'd2,
    MEM_CTRL_DONE  = 2'd3
  } mem_ctrl_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  // Width code 11 is folded into the word case.
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    case (width)
      MEM_BYTE: byte_count = 3'd1;
      MEM_HALF: byte_count = 3'd2;
      MEM_WORD: byte_count = 3'd4;
      default:  byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and sequencer for the single byte-wide RAM port: serialises IF/MEM
// requests into 1/2/4 byte accesses and reassembles little-endian read data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_width_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_data_i
);

  mem_ctrl_state_e   state_r;
  owner_e            owner_r;
  logic [2:0]        k_r;
  logic [2:0]        n_r;
  logic [ADDR_W-1:0] base_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] buf_r;

  logic              owner_req_s;
  logic              accept_any_s;
  logic [ADDR_W-1:0] accept_addr_s;
  logic [2:0]        k_next_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic [1:0]        cap_idx_s;
  logic [7:0]        wbyte_next_s;
  logic [DATA_W-1:0] asm_s;

  // Next-address, next-store-byte and read-assembly datapath.
  always_comb begin
    owner_req_s   = (owner_r == OWNER_MEM) ? mem_req_i : if_req_i;
    accept_any_s  = mem_req_i | if_req_i;
    accept_addr_s = mem_req_i ? mem_addr_i : if_addr_i;
    k_next_s      = k_r + 3'd1;
    addr_next_s   = base_r + ADDR_W'(k_next_s);
    cap_idx_s     = k_r[1:0] - 2'd1;
    wbyte_next_s  = wdata_r[{k_next_s[1:0], 3'b000} +: 8];
    asm_s         = buf_r;
    // The byte arriving now belongs to the address driven one cycle earlier.
    if (k_r != 3'd0) begin
      asm_s[{cap_idx_s, 3'b000} +: 8] = ram_data_i;
    end else begin
      asm_s = buf_r;
    end
  end

  // Sequencing FSM with all RAM and requester outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= MEM_CTRL_IDLE;
      owner_r    <= OWNER_IF;
      k_r        <= 3'd0;
      n_r        <= 3'd0;
      base_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      buf_r      <= {DATA_W{1'b0}};
      ram_addr_o <= {ADDR_W{1'b0}};
      ram_data_o <= 8'h00;
      ram_wr_o   <= 1'b0;
      if_data_o  <= {DATA_W{1'b0}};
      mem_data_o <= {DATA_W{1'b0}};
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state_r)
        MEM_CTRL_IDLE: begin
          k_r <= 3'd0;
          if (accept_any_s) begin
            owner_r    <= mem_req_i ? OWNER_MEM : OWNER_IF;
            base_r     <= accept_addr_s;
            n_r        <= mem_req_i ? byte_count(mem_width_i) : 3'd4;
            wdata_r    <= mem_wdata_i;
            buf_r      <= {DATA_W{1'b0}};
            ram_addr_o <= accept_addr_s;
            if (mem_req_i && mem_wr_i) begin
              ram_data_o <= mem_wdata_i[7:0];
              ram_wr_o   <= 1'b1;
              state_r    <= MEM_CTRL_WRITE;
            end else begin
              ram_wr_o   <= 1'b0;
              state_r    <= MEM_CTRL_READ;
            end
          end else begin
            ram_wr_o <= 1'b0;
            state_r  <= MEM_CTRL_IDLE;
          end
        end
        MEM_CTRL_READ: begin
          ram_wr_o <= 1'b0;
          if (!owner_req_s) begin
            // Flush: drop the partial word without touching the data outputs.
            k_r     <= 3'd0;
            state_r <= MEM_CTRL_IDLE;
          end else if (k_r == n_r) begin
            k_r     <= 3'd0;
            state_r <= MEM_CTRL_DONE;
            if (owner_r == OWNER_MEM) begin
              mem_data_o <= asm_s;
              mem_done_o <= 1'b1;
            end else begin
              if_data_o  <= asm_s;
              if_done_o  <= 1'b1;
            end
          end else begin
            buf_r      <= asm_s;
            k_r        <= k_next_s;
            ram_addr_o <= addr_next_s;
            state_r    <= MEM_CTRL_READ;
          end
        end
        MEM_CTRL_WRITE: begin
          // Stores ignore req so they always finish whole.
          if (k_r == (n_r - 3'd1)) begin
            ram_wr_o <= 1'b0;
            k_r      <= 3'd0;
            state_r  <= MEM_CTRL_DONE;
            if (owner_r == OWNER_MEM) begin
              mem_done_o <= 1'b1;
            end else begin
              if_done_o  <= 1'b1;
            end
          end else begin
            k_r        <= k_next_s;
            ram_addr_o <= addr_next_s;
            ram_data_o <= wbyte_next_s;
            ram_wr_o   <= 1'b1;
            state_r    <= MEM_CTRL_WRITE;
          end
        end
        MEM_CTRL_DONE: begin
          ram_wr_o <= 1'b0;
          k_r      <= 3'd0;
          state_r  <= MEM_CTRL_IDLE;
        end
        default: begin
          ram_wr_o <= 1'b0;
          k_r      <= 3'd0;
          state_r  <= MEM_CTRL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model with one-cycle read latency,
// expected read words and store bytes queued at drive time and popped on completion.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = 17'h0;
  logic [DATA_W-1:0] if_data_o;
  logic              if_done_o;
  logic              mem_req_i = 1'b0;
  logic              mem_wr_i = 1'b0;
  logic [1:0]        mem_width_i = 2'b00;
  logic [ADDR_W-1:0] mem_addr_i = 17'h0;
  logic [DATA_W-1:0] mem_wdata_i = 32'h0;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_done_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_data_o;
  logic              ram_wr_o;
  logic [7:0]        ram_rd;

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_width_i(mem_width_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_data_o(mem_data_o),
    .mem_done_o(mem_done_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_wr_o(ram_wr_o), .ram_data_i(ram_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } wr_t;

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = 17'h0;
  logic [7:0]        pl_data = 8'h00;
  int                cyc = 0;
  wr_t               wr_log[$];
  wr_t               wr_exp[$];
  logic [31:0]       if_exp[$];
  logic [31:0]       mem_exp[$];
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       last_if = 32'h0;
  localparam int     OUT_W = ADDR_W + 8 + 1 + DATA_W + DATA_W + 2;

  // RAM model: synchronous read, write on strobe, plus bench preload port.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ram_rd <= ram[ram_addr_o];
    if (ram_wr_o) begin
      ram[ram_addr_o] <= ram_data_o;
      wr_log.push_back({ram_addr_o, ram_data_o, cyc});
    end
    if (pl_en) ram[pl_addr] <= pl_data;
  end

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns edges after acceptance until done is seen (-1 if the budget runs out).
  task automatic wait_done(input bit sel_mem, input int budget, output int lat, output logic [31:0] d);
    lat = -1;
    d = 32'h0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sel_mem ? mem_done_o : if_done_o) begin
        lat = c;
        d = sel_mem ? mem_data_o : if_data_o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ram_addr_o, ram_data_o, ram_wr_o, if_data_o, mem_data_o, if_done_o, mem_done_o} !== {OUT_W{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h wdata=%h wr=%b ifd=%h memd=%h ifdn=%b memdn=%b want all zero",
               ram_addr_o, ram_data_o, ram_wr_o, if_data_o, mem_data_o, if_done_o, mem_done_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read;
    int lat; logic [31:0] d, e; int w0;
    poke(17'h00010, 8'h13); poke(17'h00011, 8'h05);
    poke(17'h00012, 8'h00); poke(17'h00013, 8'h00);
    if_exp.push_back(32'h00000513);
    w0 = wr_log.size();
    @(negedge clk);
    if_addr_i = 17'h00010; if_req_i = 1'b1;
    wait_done(1'b0, 20, lat, d);
    if_req_i = 1'b0;
    e = if_exp.pop_front();
    last_if = e;
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL if_read_latency got %0d want 5", lat); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL if_read_data got %h want %h", d, e); end
    checks++;
    if (wr_log.size() !== w0) begin errors++; $display("FAIL if_read_no_write got %0d strobes want 0", wr_log.size() - w0); end
    @(negedge clk);
    checks++;
    if (if_done_o !== 1'b0) begin errors++; $display("FAIL if_done_pulse got %b want 0", if_done_o); end
  endtask

  task automatic test_store_word;
    int lat; logic [31:0] d; int w0; wr_t ex, ob;
    logic [31:0] word;
    word = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) wr_exp.push_back({17'h00100 + 17'(i), word[8*i +: 8], 0});
    w0 = wr_log.size();
    @(negedge clk);
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_width_i = 2'b10; mem_addr_i = 17'h00100; mem_wdata_i = word;
    wait_done(1'b1, 20, lat, d);
    mem_req_i = 1'b0; mem_wr_i = 1'b0;
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL store_latency got %0d want 4", lat); end
    checks++;
    if (wr_log.size() !== w0 + 4) begin
      errors++; $display("FAIL store_strobe_count got %0d want 4", wr_log.size() - w0);
      wr_exp.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        ex = wr_exp.pop_front();
        ob = wr_log[w0 + i];
        checks++;
        if (ob.addr !== ex.addr || ob.data !== ex.data) begin
          errors++; $display("FAIL store_byte%0d got %h:%h want %h:%h", i, ob.addr, ob.data, ex.addr, ex.data);
        end
        checks++;
        if (ob.cyc !== wr_log[w0].cyc + i) begin
          errors++; $display("FAIL store_consecutive%0d got cycle %0d want %0d", i, ob.cyc, wr_log[w0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] d, e;
    poke(17'h1FFFF, 8'h80); poke(17'h00000, 8'h5A);
    mem_exp.push_back(32'h00000080);
    @(negedge clk);
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_width_i = 2'b00; mem_addr_i = 17'h1FFFF;
    wait_done(1'b1, 20, lat, d);
    mem_req_i = 1'b0;
    e = mem_exp.pop_front();
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL byte_load_latency got %0d want 2", lat); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL byte_load_data got %h want %h", d, e); end
    mem_exp.push_back(32'h00005A80);
    @(negedge clk);
    mem_req_i = 1'b1; mem_width_i = 2'b01; mem_addr_i = 17'h1FFFF;
    wait_done(1'b1, 20, lat, d);
    mem_req_i = 1'b0;
    e = mem_exp.pop_front();
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL half_wrap_latency got %0d want 3", lat); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL half_wrap_data got %h want %h", d, e); end
  endtask

  task automatic test_arbitration;
    int lat; logic [31:0] d, e; bit seen;
    poke(17'h00200, 8'h11); poke(17'h00201, 8'h22);
    poke(17'h00202, 8'h33); poke(17'h00203, 8'h44);
    mem_exp.push_back(32'h00002211);
    if_exp.push_back(32'h00000513);
    @(negedge clk);
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_width_i = 2'b01; mem_addr_i = 17'h00200;
    if_req_i = 1'b1; if_addr_i = 17'h00010;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = mem_done_o | if_done_o;
    end
    checks++;
    if (mem_done_o !== 1'b1 || if_done_o !== 1'b0) begin
      errors++; $display("FAIL arb_mem_first got mem_done=%b if_done=%b want 1 0", mem_done_o, if_done_o);
    end
    e = mem_exp.pop_front();
    checks++;
    if (mem_data_o !== e) begin errors++; $display("FAIL arb_mem_data got %h want %h", mem_data_o, e); end
    mem_req_i = 1'b0;
    wait_done(1'b0, 20, lat, d);
    if_req_i = 1'b0;
    e = if_exp.pop_front();
    last_if = e;
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL arb_if_pending_latency got %0d want 6", lat); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL arb_if_data got %h want %h", d, e); end
  endtask

  task automatic test_drop;
    int lat; logic [31:0] d; bit seen; logic [31:0] word;
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 17'h00200;
    repeat (4) @(negedge clk);
    if_req_i = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if_done_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL if_flush_no_done got done=%b want 0", seen); end
    checks++;
    if (if_data_o !== last_if) begin errors++; $display("FAIL if_flush_data_held got %h want %h", if_data_o, last_if); end
    word = 32'h01020304;
    @(negedge clk);
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_width_i = 2'b10; mem_addr_i = 17'h00300; mem_wdata_i = word;
    repeat (2) @(negedge clk);
    mem_req_i = 1'b0;
    wait_done(1'b1, 20, lat, d);
    mem_wr_i = 1'b0;
    checks++;
    if (lat < 0) begin errors++; $display("FAIL store_drop_done got timeout want done pulse"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[17'h00300 + 17'(i)] !== word[8*i +: 8]) begin
        errors++; $display("FAIL store_drop_byte%0d got %h want %h", i, ram[17'h00300 + 17'(i)], word[8*i +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat; logic [31:0] d, e; bit seen;
    @(negedge clk);
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_width_i = 2'b10; mem_addr_i = 17'h00400; mem_wdata_i = 32'hAABBCCDD;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_addr_o, ram_data_o, ram_wr_o, if_data_o, mem_data_o, if_done_o, mem_done_o} !== {OUT_W{1'b0}}) begin
      errors++;
      $display("FAIL async_reset_outputs got addr=%h wdata=%h wr=%b ifd=%h memd=%h want all zero",
               ram_addr_o, ram_data_o, ram_wr_o, if_data_o, mem_data_o);
    end
    mem_req_i = 1'b0; mem_wr_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_done_o || if_done_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done got done=%b want 0", seen); end
    if_exp.push_back(32'h44332211);
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 17'h00200;
    wait_done(1'b0, 20, lat, d);
    if_req_i = 1'b0;
    e = if_exp.pop_front();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL post_reset_latency got %0d want 5", lat); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL post_reset_data got %h want %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_store_word();
    test_wrap();
    test_arbitration();
    test_drop();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
